// File: rtl/alu_issue_stage.sv
// ID/EX issue register in front of the ALU. Holds one decoded instruction,
// resolves its operands from the register file or the EX/MEM/WB bypass
// buses at the moment it is accepted, and blocks load-use hazards.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_valid and the upstream payload must stay stable until
// in_ready is seen; out_valid and the alu_*/out_* payload stay stable until
// out_ready is seen. flush overrides both sides in the cycle it is high.
module alu_issue_stage #(
    parameter int DATAWIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           in_rs1_addr,
    input  logic [4:0]           in_rs2_addr,
    input  logic [4:0]           in_rd_addr,
    input  logic [DATAWIDTH-1:0] in_rs1_data,
    input  logic [DATAWIDTH-1:0] in_rs2_data,
    input  logic [DATAWIDTH-1:0] in_imm,
    input  logic                 in_use_imm,
    input  logic [3:0]           in_op,
    input  logic                 in_rd_we,
    input  logic                 in_is_load,
    input  logic                 flush,
    input  logic [DATAWIDTH-1:0] ex_result,
    input  logic                 fwd_mem_valid,
    input  logic                 fwd_mem_is_load,
    input  logic [4:0]           fwd_mem_addr,
    input  logic [DATAWIDTH-1:0] fwd_mem_data,
    input  logic                 fwd_wb_valid,
    input  logic [4:0]           fwd_wb_addr,
    input  logic [DATAWIDTH-1:0] fwd_wb_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] alu_rs1,
    output logic [DATAWIDTH-1:0] alu_rs2,
    output logic [3:0]           alu_op,
    output logic [4:0]           out_rd_addr,
    output logic                 out_rd_we,
    output logic                 out_is_load,
    output logic [31:0]          stall_cnt,
    output logic                 dbg_state
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [DATAWIDTH-1:0]  r_alu_rs1;
    logic [DATAWIDTH-1:0]  r_alu_rs2;
    logic [3:0]            r_alu_op;
    logic [4:0]            r_rd_addr;
    logic                  r_rd_we;
    logic                  r_is_load;
    logic [31:0]           r_stall_cnt;

    logic                  w_full;
    logic                  w_handoff;
    logic                  w_accept;
    logic                  w_held_load;
    logic                  w_mem_load;
    logic                  w_rs1_haz;
    logic                  w_rs2_haz;
    logic                  w_hazard;
    logic                  w_stall_inc;
    logic [DATAWIDTH-1:0]  w_rs1_opnd;
    logic [DATAWIDTH-1:0]  w_rs2_opnd;

    assign w_full    = (r_state == ST_FULL);
    assign w_handoff = w_full & out_ready;
    assign w_accept  = in_valid & in_ready;

    // Load-use detection: a load still held here or sitting in MEM has no
    // data yet, so any reader of its rd must wait.
    always_comb begin
        w_held_load = w_full & r_is_load & r_rd_we;
        w_mem_load  = fwd_mem_valid & fwd_mem_is_load;
        w_rs1_haz   = (in_rs1_addr != 5'd0) &
                      ((w_held_load & (r_rd_addr == in_rs1_addr)) |
                       (w_mem_load & (fwd_mem_addr == in_rs1_addr)));
        w_rs2_haz   = !in_use_imm & (in_rs2_addr != 5'd0) &
                      ((w_held_load & (r_rd_addr == in_rs2_addr)) |
                       (w_mem_load & (fwd_mem_addr == in_rs2_addr)));
        w_hazard    = w_rs1_haz | w_rs2_haz;
    end

    assign in_ready    = !RST & !flush & !w_hazard & (!w_full | out_ready);
    assign w_stall_inc = in_valid & w_hazard & !flush;

    // rs1 operand: EX (only when the held instruction leaves now), then MEM,
    // then WB, then register file. x0 never takes a bypass.
    always_comb begin
        w_rs1_opnd = in_rs1_data;
        if (in_rs1_addr != 5'd0) begin
            if (w_handoff & r_rd_we & (r_rd_addr == in_rs1_addr)) begin
                w_rs1_opnd = ex_result;
            end else if (fwd_mem_valid & (fwd_mem_addr == in_rs1_addr)) begin
                w_rs1_opnd = fwd_mem_data;
            end else if (fwd_wb_valid & (fwd_wb_addr == in_rs1_addr)) begin
                w_rs1_opnd = fwd_wb_data;
            end
        end
    end

    // rs2 operand: immediate wins outright, otherwise same priority as rs1.
    always_comb begin
        w_rs2_opnd = in_rs2_data;
        if (in_use_imm) begin
            w_rs2_opnd = in_imm;
        end else if (in_rs2_addr != 5'd0) begin
            if (w_handoff & r_rd_we & (r_rd_addr == in_rs2_addr)) begin
                w_rs2_opnd = ex_result;
            end else if (fwd_mem_valid & (fwd_mem_addr == in_rs2_addr)) begin
                w_rs2_opnd = fwd_mem_data;
            end else if (fwd_wb_valid & (fwd_wb_addr == in_rs2_addr)) begin
                w_rs2_opnd = fwd_wb_data;
            end
        end
    end

    // Next state: flush empties the stage, accept fills it, handoff drains it.
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else if (w_accept) begin
            w_state_nxt = ST_FULL;
        end else if (w_handoff) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Payload capture; operands are frozen at accept and never re-resolved.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_alu_rs1 <= '0;
            r_alu_rs2 <= '0;
            r_alu_op  <= '0;
            r_rd_addr <= '0;
            r_rd_we   <= 1'b0;
            r_is_load <= 1'b0;
        end else if (w_accept) begin
            r_alu_rs1 <= w_rs1_opnd;
            r_alu_rs2 <= w_rs2_opnd;
            r_alu_op  <= in_op;
            r_rd_addr <= in_rd_addr;
            r_rd_we   <= in_rd_we;
            r_is_load <= in_is_load;
        end
    end

    // Saturating hazard stall counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_stall_cnt <= '0;
        end else if (w_stall_inc && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign out_valid   = w_full;
    assign alu_rs1     = r_alu_rs1;
    assign alu_rs2     = r_alu_rs2;
    assign alu_op      = r_alu_op;
    assign out_rd_addr = r_rd_addr;
    assign out_rd_we   = r_rd_we;
    assign out_is_load = r_is_load;
    assign stall_cnt   = r_stall_cnt;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios plus a randomized run, all
// checked against a cycle-level reference model of the issue stage.
module tb_alu_issue_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid, in_ready;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic [31:0] in_rs1_data, in_rs2_data, in_imm;
    logic        in_use_imm;
    logic [3:0]  in_op;
    logic        in_rd_we, in_is_load, flush;
    logic [31:0] ex_result;
    logic        fwd_mem_valid, fwd_mem_is_load;
    logic [4:0]  fwd_mem_addr;
    logic [31:0] fwd_mem_data;
    logic        fwd_wb_valid;
    logic [4:0]  fwd_wb_addr;
    logic [31:0] fwd_wb_data;
    logic        out_valid, out_ready;
    logic [31:0] alu_rs1, alu_rs2;
    logic [3:0]  alu_op;
    logic [4:0]  out_rd_addr;
    logic        out_rd_we, out_is_load;
    logic [31:0] stall_cnt;
    logic        dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q[$];

    // reference model state
    bit          m_valid;
    logic [31:0] m_rs1, m_rs2, m_stall;
    logic [3:0]  m_op;
    logic [4:0]  m_rd;
    bit          m_we, m_ld;

    alu_issue_stage #(.DATAWIDTH(32)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_use_imm(in_use_imm), .in_op(in_op), .in_rd_we(in_rd_we),
        .in_is_load(in_is_load), .flush(flush), .ex_result(ex_result),
        .fwd_mem_valid(fwd_mem_valid), .fwd_mem_is_load(fwd_mem_is_load),
        .fwd_mem_addr(fwd_mem_addr), .fwd_mem_data(fwd_mem_data),
        .fwd_wb_valid(fwd_wb_valid), .fwd_wb_addr(fwd_wb_addr), .fwd_wb_data(fwd_wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
        .alu_op(alu_op), .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we),
        .out_is_load(out_is_load), .stall_cnt(stall_cnt), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    task automatic mdl_reset();
        m_valid = 0; m_rs1 = 0; m_rs2 = 0; m_op = 0; m_rd = 0;
        m_we = 0; m_ld = 0; m_stall = 0;
        exp_q.delete();
    endtask

    function automatic bit mdl_dep(input logic [4:0] r, input bit en, input logic [4:0] a);
        return (r != 5'd0) && en && (a == r);
    endfunction

    function automatic bit mdl_hazard();
        bit held  = m_valid && m_ld && m_we;
        bit memld = (fwd_mem_valid === 1'b1) && (fwd_mem_is_load === 1'b1);
        bit h     = mdl_dep(in_rs1_addr, held, m_rd) || mdl_dep(in_rs1_addr, memld, fwd_mem_addr);
        if (in_use_imm !== 1'b1)
            h = h || mdl_dep(in_rs2_addr, held, m_rd) || mdl_dep(in_rs2_addr, memld, fwd_mem_addr);
        return h;
    endfunction

    function automatic bit mdl_ready();
        return (RST !== 1'b1) && (flush !== 1'b1) && !mdl_hazard() &&
               (!m_valid || (out_ready === 1'b1));
    endfunction

    // first matching source in priority order EX, MEM, WB; x0 never bypassed
    function automatic logic [31:0] mdl_opnd(input logic [4:0] r, input logic [31:0] rf);
        bit          en[3];
        logic [4:0]  ad[3];
        logic [31:0] dt[3];
        en[0] = m_valid && (out_ready === 1'b1) && m_we; ad[0] = m_rd;         dt[0] = ex_result;
        en[1] = (fwd_mem_valid === 1'b1);               ad[1] = fwd_mem_addr;  dt[1] = fwd_mem_data;
        en[2] = (fwd_wb_valid === 1'b1);                ad[2] = fwd_wb_addr;   dt[2] = fwd_wb_data;
        if (r == 5'd0) return rf;
        for (int k = 0; k < 3; k++)
            if (en[k] && ad[k] == r) return dt[k];
        return rf;
    endfunction

    // advance the model by one clock using the inputs currently applied
    task automatic mdl_edge();
        bit          acc = (in_valid === 1'b1) && mdl_ready();
        bit          hs  = m_valid && (out_ready === 1'b1);
        logic [31:0] o1  = mdl_opnd(in_rs1_addr, in_rs1_data);
        logic [31:0] o2  = (in_use_imm === 1'b1) ? in_imm : mdl_opnd(in_rs2_addr, in_rs2_data);
        if ((in_valid === 1'b1) && mdl_hazard() && (flush !== 1'b1) && m_stall != 32'hFFFF_FFFF)
            m_stall = m_stall + 1;
        if (flush === 1'b1) begin
            m_valid = 0;
        end else if (acc) begin
            m_valid = 1; m_rs1 = o1; m_rs2 = o2; m_op = in_op;
            m_rd = in_rd_addr; m_we = in_rd_we; m_ld = in_is_load;
        end else if (hs) begin
            m_valid = 0;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        mdl_edge();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_rs1_addr = 0; in_rs2_addr = 0; in_rd_addr = 0;
        in_rs1_data = 0; in_rs2_data = 0; in_imm = 0; in_use_imm = 0; in_op = 0;
        in_rd_we = 0; in_is_load = 0; flush = 0; ex_result = 0;
        fwd_mem_valid = 0; fwd_mem_is_load = 0; fwd_mem_addr = 0; fwd_mem_data = 0;
        fwd_wb_valid = 0; fwd_wb_addr = 0; fwd_wb_data = 0;
    endtask

    task automatic set_instr(input logic [4:0] r1, input logic [31:0] d1,
                             input logic [4:0] r2, input logic [31:0] d2,
                             input logic [4:0] rd, input logic [3:0] op,
                             input logic we, input logic ld,
                             input logic ui, input logic [31:0] imm);
        in_valid = 1; in_rs1_addr = r1; in_rs1_data = d1; in_rs2_addr = r2;
        in_rs2_data = d2; in_rd_addr = rd; in_op = op; in_rd_we = we;
        in_is_load = ld; in_use_imm = ui; in_imm = imm;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        RST = 1; out_ready = 1; idle_inputs(); mdl_reset();
        #2;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %0h exp 0", in_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0h exp 0", out_valid); end
        n_tests++; if ({alu_rs1, alu_rs2, alu_op, out_rd_addr, out_rd_we, out_is_load} !== '0) begin
            n_fail++; $display("FAIL reset_payload got %h/%h/%h/%h exp all 0", alu_rs1, alu_rs2, alu_op, out_rd_addr); end
        n_tests++; if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_stall_cnt got %0h exp 0", stall_cnt); end
        @(posedge CLK); @(posedge CLK); #1;
        RST = 0;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got %0h exp 1", in_ready); end
        @(posedge CLK); #1;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            set_instr(5'd3, 32'd5 + i, 5'd4, 32'd7 + i, 5'd8 + 5'(i), 4'(i), 1, 0, 0, 0);
            #1;
            n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d] got %0h exp 1", i, in_ready); end
            tick();
            n_tests++; if (alu_rs1 !== 32'd5 + i || alu_rs2 !== 32'd7 + i || alu_op !== 4'(i) || out_valid !== 1'b1) begin
                n_fail++; $display("FAIL b2b_out[%0d] got rs1=%0h rs2=%0h op=%0h v=%0h exp %0h %0h %0h 1",
                                   i, alu_rs1, alu_rs2, alu_op, out_valid, 5 + i, 7 + i, i); end
        end
        idle_inputs(); tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %0h exp 0", out_valid); end
    endtask

    task automatic test_ex_bypass();
        set_instr(5'd1, 32'd1, 5'd2, 32'd2, 5'd5, 4'd0, 1, 0, 0, 0);
        #1; tick();
        ex_result = 32'h10; out_ready = 1;
        set_instr(5'd5, 32'd0, 5'd2, 32'd3, 5'd9, 4'd1, 1, 0, 0, 0);
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ex_in_ready got %0h exp 1", in_ready); end
        tick();
        n_tests++; if (alu_rs1 !== 32'h10 || alu_rs1 !== m_rs1) begin
            n_fail++; $display("FAIL ex_bypass got %0h exp 10", alu_rs1); end
        idle_inputs(); tick();
    endtask

    task automatic test_priority();
        fwd_mem_valid = 1; fwd_mem_addr = 5'd6; fwd_mem_data = 32'hAA;
        fwd_wb_valid  = 1; fwd_wb_addr  = 5'd6; fwd_wb_data  = 32'hBB;
        set_instr(5'd6, 32'h11, 5'd2, 32'h22, 5'd0, 4'd3, 1, 0, 0, 0);
        #1; tick();
        n_tests++; if (alu_rs1 !== 32'hAA || alu_rs2 !== 32'h22) begin
            n_fail++; $display("FAIL prio_mem got rs1=%0h rs2=%0h exp aa 22", alu_rs1, alu_rs2); end
        // held instruction writes x0 and is handed off: no source may hit x0
        fwd_mem_addr = 5'd0; fwd_wb_addr = 5'd0; ex_result = 32'hEE;
        set_instr(5'd0, 32'h123, 5'd0, 32'h456, 5'd1, 4'd4, 1, 0, 0, 0);
        #1; tick();
        n_tests++; if (alu_rs1 !== 32'h123 || alu_rs2 !== 32'h456) begin
            n_fail++; $display("FAIL prio_x0 got rs1=%0h rs2=%0h exp 123 456", alu_rs1, alu_rs2); end
        idle_inputs(); tick();
    endtask

    task automatic test_load_use();
        set_instr(5'd1, 32'd0, 5'd2, 32'd0, 5'd7, 4'd0, 1, 1, 0, 0);
        #1; tick();
        set_instr(5'd7, 32'hDEAD, 5'd3, 32'h33, 5'd10, 4'd2, 1, 0, 0, 0);
        #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL lu_stall_held got %0h exp 0", in_ready); end
        tick();
        fwd_mem_valid = 1; fwd_mem_is_load = 1; fwd_mem_addr = 5'd7;
        #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL lu_stall_mem got %0h exp 0", in_ready); end
        tick();
        fwd_mem_valid = 0; fwd_mem_is_load = 0; fwd_mem_addr = 0;
        fwd_wb_valid = 1; fwd_wb_addr = 5'd7; fwd_wb_data = 32'hCAFE_F00D;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL lu_release got %0h exp 1", in_ready); end
        tick();
        n_tests++; if (alu_rs1 !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL lu_wb_operand got %0h exp cafef00d", alu_rs1); end
        n_tests++; if (stall_cnt !== 32'd2) begin n_fail++; $display("FAIL lu_stall_cnt got %0d exp 2", stall_cnt); end
        idle_inputs(); tick();
        // immediate form does not depend on rs2
        set_instr(5'd1, 32'd0, 5'd2, 32'd0, 5'd7, 4'd0, 1, 1, 0, 0);
        #1; tick();
        set_instr(5'd1, 32'h1, 5'd7, 32'h77, 5'd11, 4'd6, 1, 0, 1, 32'h44);
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL lu_imm_ready got %0h exp 1", in_ready); end
        tick();
        n_tests++; if (alu_rs2 !== 32'h44 || stall_cnt !== 32'd2) begin
            n_fail++; $display("FAIL lu_imm got rs2=%0h cnt=%0d exp 44 2", alu_rs2, stall_cnt); end
        idle_inputs(); tick();
    endtask

    task automatic test_backpressure_flush();
        set_instr(5'd2, 32'h200, 5'd3, 32'h300, 5'd11, 4'd5, 1, 0, 0, 0);
        #1; tick();
        out_ready = 0;
        set_instr(5'd4, 32'h400, 5'd5, 32'h500, 5'd12, 4'd6, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got %0h exp 0", i, in_ready); end
            tick();
            n_tests++; if (alu_rs1 !== 32'h200 || alu_rs2 !== 32'h300 || alu_op !== 4'd5 || out_valid !== 1'b1) begin
                n_fail++; $display("FAIL bp_hold[%0d] got %0h %0h %0h v=%0h exp 200 300 5 1", i, alu_rs1, alu_rs2, alu_op, out_valid); end
        end
        flush = 1; out_ready = 1;
        #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got %0h exp 0", in_ready); end
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got %0h exp 0", out_valid); end
        idle_inputs(); tick();
        n_tests++; if (out_valid !== 1'b0 || alu_rs1 !== 32'h200) begin
            n_fail++; $display("FAIL flush_drop got v=%0h rs1=%0h exp 0 200", out_valid, alu_rs1); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bit          acc, hs;
            logic [31:0] o1;
            in_valid    = ($urandom_range(0, 3) != 0);
            in_rs1_addr = 5'($urandom_range(0, 7));
            in_rs2_addr = 5'($urandom_range(0, 7));
            in_rd_addr  = 5'($urandom_range(0, 7));
            in_rs1_data = $urandom; in_rs2_data = $urandom; in_imm = $urandom;
            in_use_imm  = ($urandom_range(0, 3) == 0);
            in_op       = 4'($urandom_range(0, 15));
            in_rd_we    = ($urandom_range(0, 3) != 0);
            in_is_load  = ($urandom_range(0, 3) == 0);
            flush       = ($urandom_range(0, 19) == 0);
            ex_result   = $urandom;
            fwd_mem_valid = $urandom_range(0, 1); fwd_mem_is_load = ($urandom_range(0, 4) == 0);
            fwd_mem_addr  = 5'($urandom_range(0, 7)); fwd_mem_data = $urandom;
            fwd_wb_valid  = $urandom_range(0, 1);
            fwd_wb_addr   = 5'($urandom_range(0, 7)); fwd_wb_data = $urandom;
            out_ready   = ($urandom_range(0, 3) != 0);
            #1;
            n_tests++; if (in_ready !== mdl_ready()) begin
                n_fail++; $display("FAIL rnd_in_ready[%0d] got %0h exp %0h", c, in_ready, mdl_ready()); end
            acc = (in_valid === 1'b1) && mdl_ready();
            hs  = m_valid && (out_ready === 1'b1);
            o1  = mdl_opnd(in_rs1_addr, in_rs1_data);
            if (flush === 1'b1) begin
                exp_q.delete();
            end else begin
                if (hs) begin
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++; $display("FAIL rnd_sb_empty[%0d] got rs1=%0h exp nothing pending", c, alu_rs1);
                    end else if (alu_rs1 !== exp_q[0]) begin
                        n_fail++; $display("FAIL rnd_sb_rs1[%0d] got %0h exp %0h", c, alu_rs1, exp_q[0]);
                    end
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end
                if (acc) exp_q.push_back(o1);
            end
            tick();
            n_tests++; if (out_valid !== m_valid || stall_cnt !== m_stall) begin
                n_fail++; $display("FAIL rnd_ctrl[%0d] got v=%0h cnt=%0d exp %0h %0d", c, out_valid, stall_cnt, m_valid, m_stall); end
            n_tests++; if (alu_rs1 !== m_rs1 || alu_rs2 !== m_rs2 || alu_op !== m_op) begin
                n_fail++; $display("FAIL rnd_alu[%0d] got %0h %0h %0h exp %0h %0h %0h", c, alu_rs1, alu_rs2, alu_op, m_rs1, m_rs2, m_op); end
            n_tests++; if (out_rd_addr !== m_rd || out_rd_we !== m_we || out_is_load !== m_ld) begin
                n_fail++; $display("FAIL rnd_rd[%0d] got %0h %0h %0h exp %0h %0h %0h", c, out_rd_addr, out_rd_we, out_is_load, m_rd, m_we, m_ld); end
        end
        idle_inputs(); out_ready = 1; tick(); exp_q.delete();
    endtask

    task automatic test_saturation_reset();
        out_ready = 0;
        set_instr(5'd1, 32'h1, 5'd2, 32'h2, 5'd12, 4'd7, 1, 0, 0, 0);
        #1; tick();
        force dut.r_stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_stall_cnt;
        m_stall = 32'hFFFF_FFFE;
        n_tests++; if (stall_cnt !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL sat_preload got %0h exp fffffffe", stall_cnt); end
        fwd_mem_valid = 1; fwd_mem_is_load = 1; fwd_mem_addr = 5'd9;
        set_instr(5'd9, 32'h9, 5'd2, 32'h2, 5'd13, 4'd1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if (stall_cnt !== 32'hFFFF_FFFF || stall_cnt !== m_stall) begin
                n_fail++; $display("FAIL sat_cnt[%0d] got %0h exp ffffffff", i, stall_cnt); end
        end
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sat_held got %0h exp 1", out_valid); end
        RST = 1;
        #1;
        n_tests++; if (out_valid !== 1'b0 || stall_cnt !== 32'd0 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL async_reset got v=%0h cnt=%0h rdy=%0h exp 0 0 0", out_valid, stall_cnt, in_ready); end
        n_tests++; if (alu_rs1 !== 32'd0 || alu_op !== 4'd0) begin
            n_fail++; $display("FAIL async_reset_payload got %0h %0h exp 0 0", alu_rs1, alu_op); end
        idle_inputs(); mdl_reset();
        @(posedge CLK); #1;
        RST = 0;
        @(posedge CLK); #1;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_ex_bypass();
        test_priority();
        test_load_use();
        test_backpressure_flush();
        test_random();
        test_saturation_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
